// File: rtl/vga_pkg.sv
// Shared constants for the raster timing generator: the standard 640x480@60
// mode and a tiny mode that keeps simulations short.
package vga_pkg;

    localparam int DEF_H_WIDTH  = 640;
    localparam int DEF_H_PORCH  = 656;
    localparam int DEF_H_SYNCH  = 752;
    localparam int DEF_H_RAW    = 800;
    localparam int DEF_V_HEIGHT = 480;
    localparam int DEF_V_PORCH  = 490;
    localparam int DEF_V_SYNCH  = 492;
    localparam int DEF_V_RAW    = 525;

    localparam int SIM_H_WIDTH  = 16;
    localparam int SIM_H_PORCH  = 18;
    localparam int SIM_H_SYNCH  = 20;
    localparam int SIM_H_RAW    = 24;
    localparam int SIM_V_HEIGHT = 4;
    localparam int SIM_V_PORCH  = 5;
    localparam int SIM_V_SYNCH  = 6;
    localparam int SIM_V_RAW    = 8;

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: a wrapping position counter plus its active and sync
// window decodes against the latched mode.
module vga_axis_ctr #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] len,
    input  logic [W-1:0] porch,
    input  logic [W-1:0] synch,
    input  logic [W-1:0] raw,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        wrap   = (count == raw - 1'b1);
        active = (count < len);
        sync   = (count >= porch) && (count < synch);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: drives the pixel-source handshake from the counters
// and re-times the returned pixel so sync, de and RGB leave aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   BITS_PER_COLOR = 4,
    parameter int   HW             = 12,
    parameter int   VW             = 12,
    parameter logic HSYNC_POL      = 1'b0,
    parameter logic VSYNC_POL      = 1'b0
) (
    input  logic                      i_pixclk,
    input  logic                      i_reset,
    input  logic [HW-1:0]             i_hm_width,
    input  logic [HW-1:0]             i_hm_porch,
    input  logic [HW-1:0]             i_hm_synch,
    input  logic [HW-1:0]             i_hm_raw,
    input  logic [VW-1:0]             i_vm_height,
    input  logic [VW-1:0]             i_vm_porch,
    input  logic [VW-1:0]             i_vm_synch,
    input  logic [VW-1:0]             i_vm_raw,
    input  logic [3*BITS_PER_COLOR-1:0] i_pixel,
    output logic                      o_rd,
    output logic                      o_newline,
    output logic                      o_newframe,
    output logic [HW-1:0]             o_width,
    output logic [VW-1:0]             o_height,
    output logic                      o_hsync,
    output logic                      o_vsync,
    output logic                      o_de,
    output logic [BITS_PER_COLOR-1:0] o_red,
    output logic [BITS_PER_COLOR-1:0] o_grn,
    output logic [BITS_PER_COLOR-1:0] o_blu,
    output logic                      o_cfg_err
);

    localparam int BPP = 3 * BITS_PER_COLOR;

    logic [HW-1:0] h_width, h_porch, h_synch, h_raw;
    logic [VW-1:0] v_height, v_porch, v_synch, v_raw;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    logic          mode_ok, frame_origin, capture, cfg_err;
    logic          hs0, vs0, rd1, hs1, vs1;

    always_comb begin
        mode_ok = (i_hm_width != '0)
                  && (i_hm_width  < i_hm_porch) && (i_hm_porch < i_hm_synch) && (i_hm_synch <= i_hm_raw)
                  && (i_vm_height < i_vm_porch) && (i_vm_porch < i_vm_synch) && (i_vm_synch <= i_vm_raw);
        // newframe is registered, so the counters already sit at the origin when it is seen
        frame_origin = (h_count == '0) && (v_count == '0);
        capture      = i_reset || (o_newframe && frame_origin);
    end

    // A rejected mode at reset has nothing valid to keep, so it falls back to 640x480.
    always_ff @(posedge i_pixclk) begin
        if (capture) begin
            if (mode_ok) begin
                h_width  <= i_hm_width;
                h_porch  <= i_hm_porch;
                h_synch  <= i_hm_synch;
                h_raw    <= i_hm_raw;
                v_height <= i_vm_height;
                v_porch  <= i_vm_porch;
                v_synch  <= i_vm_synch;
                v_raw    <= i_vm_raw;
                cfg_err  <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
                if (i_reset) begin
                    h_width  <= HW'(DEF_H_WIDTH);
                    h_porch  <= HW'(DEF_H_PORCH);
                    h_synch  <= HW'(DEF_H_SYNCH);
                    h_raw    <= HW'(DEF_H_RAW);
                    v_height <= VW'(DEF_V_HEIGHT);
                    v_porch  <= VW'(DEF_V_PORCH);
                    v_synch  <= VW'(DEF_V_SYNCH);
                    v_raw    <= VW'(DEF_V_RAW);
                end
            end
        end
    end

    assign o_width   = h_width;
    assign o_height  = v_height;
    assign o_cfg_err = cfg_err;

    vga_axis_ctr #(.W(HW)) u_hctr (
        .clk    (i_pixclk),
        .reset  (i_reset),
        .enable (1'b1),
        .len    (h_width),
        .porch  (h_porch),
        .synch  (h_synch),
        .raw    (h_raw),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    vga_axis_ctr #(.W(VW)) u_vctr (
        .clk    (i_pixclk),
        .reset  (i_reset),
        .enable (h_wrap),
        .len    (v_height),
        .porch  (v_porch),
        .synch  (v_synch),
        .raw    (v_raw),
        .count  (v_count),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    // Syncs ride hs0/hs1 alongside o_rd/rd1 so they see the same two stages as the pixel.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            o_rd       <= 1'b0;
            o_newline  <= 1'b0;
            o_newframe <= 1'b0;
            hs0        <= 1'b0;
            vs0        <= 1'b0;
            rd1        <= 1'b0;
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            o_de       <= 1'b0;
            o_red      <= '0;
            o_grn      <= '0;
            o_blu      <= '0;
            o_hsync    <= ~HSYNC_POL;
            o_vsync    <= ~VSYNC_POL;
        end else begin
            o_rd       <= h_active && v_active;
            o_newline  <= h_wrap;
            o_newframe <= h_wrap && v_wrap;
            hs0        <= h_sync;
            vs0        <= v_sync;
            rd1        <= o_rd;
            hs1        <= hs0;
            vs1        <= vs0;
            o_de       <= rd1;
            o_red      <= rd1 ? i_pixel[BPP-1 -: BITS_PER_COLOR] : '0;
            o_grn      <= rd1 ? i_pixel[2*BITS_PER_COLOR-1 -: BITS_PER_COLOR] : '0;
            o_blu      <= rd1 ? i_pixel[BITS_PER_COLOR-1:0] : '0;
            o_hsync    <= hs1 ? HSYNC_POL : ~HSYNC_POL;
            o_vsync    <= vs1 ? VSYNC_POL : ~VSYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen in the small simulation mode: a source
// model feeds tagged pixels into a scoreboard, a monitor checks line/frame
// structure, and the main sequence covers reset, bad modes and mid-line reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int BPC = 4;
    localparam int BPP = 3 * BPC;
    localparam int HW  = 12;
    localparam int VW  = 12;
    localparam int LINE_CYC  = SIM_H_RAW;
    localparam int FRAME_CYC = SIM_H_RAW * SIM_V_RAW;
    localparam int RD_FRAME  = SIM_H_WIDTH * SIM_V_HEIGHT;

    logic           clk = 1'b0;
    logic           i_reset = 1'b1;
    logic [HW-1:0]  hm_width, hm_porch, hm_synch, hm_raw;
    logic [VW-1:0]  vm_height, vm_porch, vm_synch, vm_raw;
    logic [BPP-1:0] i_pixel = '0;
    logic           o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_de, o_cfg_err;
    logic [HW-1:0]  o_width;
    logic [VW-1:0]  o_height;
    logic [BPC-1:0] o_red, o_grn, o_blu;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .BITS_PER_COLOR (BPC),
        .HW             (HW),
        .VW             (VW),
        .HSYNC_POL      (1'b0),
        .VSYNC_POL      (1'b0)
    ) dut (
        .i_pixclk    (clk),
        .i_reset     (i_reset),
        .i_hm_width  (hm_width),
        .i_hm_porch  (hm_porch),
        .i_hm_synch  (hm_synch),
        .i_hm_raw    (hm_raw),
        .i_vm_height (vm_height),
        .i_vm_porch  (vm_porch),
        .i_vm_synch  (vm_synch),
        .i_vm_raw    (vm_raw),
        .i_pixel     (i_pixel),
        .o_rd        (o_rd),
        .o_newline   (o_newline),
        .o_newframe  (o_newframe),
        .o_width     (o_width),
        .o_height    (o_height),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de),
        .o_red       (o_red),
        .o_grn       (o_grn),
        .o_blu       (o_blu),
        .o_cfg_err   (o_cfg_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int hw, input int hp, input int hs, input int hr,
                                 input int vh, input int vp, input int vs, input int vr);
        hm_width  = HW'(hw);
        hm_porch  = HW'(hp);
        hm_synch  = HW'(hs);
        hm_raw    = HW'(hr);
        vm_height = VW'(vh);
        vm_porch  = VW'(vp);
        vm_synch  = VW'(vs);
        vm_raw    = VW'(vr);
    endtask

    typedef struct {
        logic [BPP-1:0] pix;
        int             cyc;
    } pix_t;

    pix_t           sbq[$];
    pix_t           exp_e;
    int             cyc = 0;
    logic [BPP-1:0] tag = '0;
    logic [BPP-1:0] pendPix;
    int             pendCyc;
    bit             pendValid = 0;
    bit             dePrev = 0, hsPrev = 1, vsPrev = 1;
    bit             nlValid = 0, nfValid = 0, deFallValid = 0, hsFallValid = 0, vsFallValid = 0;
    int             nlCyc, nfCyc, deFallCyc, hsFallCyc, vsFallCyc;
    int             runLen = 0, rdInFrame = 0, framesSeen = 0;

    // Monitor and source model; everything is sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (i_reset) begin
            sbq.delete();
            pendValid   = 0;
            dePrev      = 0;
            hsPrev      = 1;
            vsPrev      = 1;
            nlValid     = 0;
            nfValid     = 0;
            deFallValid = 0;
            hsFallValid = 0;
            vsFallValid = 0;
            runLen      = 0;
            rdInFrame   = 0;
        end else begin
            if (o_de) begin
                if (sbq.size() == 0) begin
                    checkOutput("sb_underflow", 1, 0);
                end else begin
                    exp_e = sbq.pop_front();
                    checkOutput("rgb", {o_red, o_grn, o_blu}, exp_e.pix);
                    checkOutput("latency", cyc - exp_e.cyc, 2);
                end
                runLen++;
            end else begin
                checkOutput("rgb_blank", {o_red, o_grn, o_blu}, 0);
                if (dePrev) begin
                    checkOutput("de_run", runLen, SIM_H_WIDTH);
                    deFallCyc   = cyc;
                    deFallValid = 1;
                end
                runLen = 0;
            end

            if (!o_hsync && hsPrev) begin
                if (deFallValid) checkOutput("hs_offset", cyc - deFallCyc, 2);
                deFallValid = 0;
                hsFallCyc   = cyc;
                hsFallValid = 1;
            end
            if (o_hsync && !hsPrev && hsFallValid)
                checkOutput("hs_len", cyc - hsFallCyc, SIM_H_SYNCH - SIM_H_PORCH);

            if (!o_vsync && vsPrev) begin
                vsFallCyc   = cyc;
                vsFallValid = 1;
            end
            if (o_vsync && !vsPrev && vsFallValid)
                checkOutput("vs_len", cyc - vsFallCyc, LINE_CYC);

            if (o_newline) begin
                checkOutput("rd_nl_excl", o_rd, 0);
                if (nlValid) checkOutput("nl_period", cyc - nlCyc, LINE_CYC);
                nlCyc   = cyc;
                nlValid = 1;
            end
            if (o_newframe) begin
                checkOutput("nf_with_nl", o_newline, 1);
                if (nfValid) begin
                    checkOutput("nf_period", cyc - nfCyc, FRAME_CYC);
                    checkOutput("rd_per_frame", rdInFrame, RD_FRAME);
                end
                nfCyc     = cyc;
                nfValid   = 1;
                rdInFrame = 0;
                framesSeen++;
            end

            if (pendValid) begin
                i_pixel = pendPix;
                sbq.push_back('{pix: pendPix, cyc: pendCyc});
                pendValid = 0;
            end else begin
                i_pixel = BPP'($urandom);
            end
            if (o_rd) begin
                pendPix   = tag;
                pendCyc   = cyc;
                pendValid = 1;
                tag       = tag + 1'b1;
                rdInFrame++;
            end

            dePrev = o_de;
            hsPrev = o_hsync;
            vsPrev = o_vsync;
        end
    end

    task automatic waitEvent(input bit frame, input int budget, input string tag_s);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (frame ? o_newframe : o_newline) found = 1;
        end
        if (!found) checkOutput(tag_s, 0, 1);
    endtask

    // Called right after reset drops: o_rd rises one cycle later, newline after a full line.
    task automatic firstNewline(input string tag_s);
        int n = 0;
        for (int k = 1; k <= 2 * LINE_CYC; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput("rd_rise", o_rd, 1);
            if (o_newline) begin
                n = k;
                break;
            end
        end
        checkOutput(tag_s, n, LINE_CYC);
    endtask

    task automatic checkResetOutputs(input string tag_s);
        checkOutput({tag_s, "_rd"}, o_rd, 0);
        checkOutput({tag_s, "_nl"}, o_newline, 0);
        checkOutput({tag_s, "_nf"}, o_newframe, 0);
        checkOutput({tag_s, "_de"}, o_de, 0);
        checkOutput({tag_s, "_rgb"}, {o_red, o_grn, o_blu}, 0);
        checkOutput({tag_s, "_hs"}, o_hsync, 1);
        checkOutput({tag_s, "_vs"}, o_vsync, 1);
    endtask

    initial begin
        applyStimulus(SIM_H_WIDTH, SIM_H_PORCH, SIM_H_SYNCH, SIM_H_RAW,
                      SIM_V_HEIGHT, SIM_V_PORCH, SIM_V_SYNCH, SIM_V_RAW);
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        checkOutput("reset_cfg_err", o_cfg_err, 0);
        checkOutput("reset_width", o_width, SIM_H_WIDTH);
        checkOutput("reset_height", o_height, SIM_V_HEIGHT);
        i_reset = 1'b0;
        checkOutput("rd_first_cycle", o_rd, 0);
        firstNewline("first_nl");

        repeat (2 * FRAME_CYC + 10) @(negedge clk);
        checkOutput("frames_seen", framesSeen >= 2, 1);

        // Illegal mode (width not below porch) presented mid-frame.
        waitEvent(1, FRAME_CYC + 10, "timeout_nf1");
        repeat (40) @(negedge clk);
        applyStimulus(20, 18, SIM_H_SYNCH, SIM_H_RAW,
                      SIM_V_HEIGHT, SIM_V_PORCH, SIM_V_SYNCH, SIM_V_RAW);
        repeat (20) @(negedge clk);
        checkOutput("bad_midframe_width", o_width, SIM_H_WIDTH);
        checkOutput("bad_midframe_err", o_cfg_err, 0);
        waitEvent(1, FRAME_CYC + 10, "timeout_nf2");
        @(negedge clk);
        checkOutput("bad_err", o_cfg_err, 1);
        checkOutput("bad_width_kept", o_width, SIM_H_WIDTH);
        repeat (30) @(negedge clk);
        applyStimulus(SIM_H_WIDTH, SIM_H_PORCH, SIM_H_SYNCH, SIM_H_RAW,
                      SIM_V_HEIGHT, SIM_V_PORCH, SIM_V_SYNCH, SIM_V_RAW);
        @(negedge clk);
        checkOutput("restore_midframe_err", o_cfg_err, 1);
        waitEvent(1, FRAME_CYC + 10, "timeout_nf3");
        @(negedge clk);
        checkOutput("restore_err", o_cfg_err, 0);

        // Reset asserted at hcount 10 on the first active row.
        waitEvent(1, FRAME_CYC + 10, "timeout_nf4");
        repeat (10) @(negedge clk);
        checkOutput("rd_before_reset", o_rd, 1);
        i_reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("midreset");
        @(negedge clk);
        i_reset = 1'b0;
        firstNewline("midreset_first_nl");

        repeat (FRAME_CYC + 10) @(negedge clk);
        checkOutput("frames_after_reset", framesSeen >= 6, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
